// File: rtl/meh16_pkg.sv
// rtl/meh16_pkg.sv - shared op encodings, stack defaults and FSM states for the stack unit
package meh16_pkg;

  localparam logic [11:0] STACK_TOP_DEF   = 12'hFFF;
  localparam logic [11:0] STACK_LIMIT_DEF = 12'hC00;

  // Codes 6 and 7 are deliberately absent and decode as NOP.
  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_PSH = 3'd1,
    OP_POP = 3'd2,
    OP_MSW = 3'd3,
    OP_CAL = 3'd4,
    OP_RET = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_CMP  = 2'd3
  } state_e;

  // Ops that write one word below SP.
  function automatic logic is_write_op(input logic [2:0] op);
    return (op == OP_PSH) || (op == OP_CAL);
  endfunction

  // Ops that read one word above SP (plus an optional offset).
  function automatic logic is_read_op(input logic [2:0] op);
    return (op == OP_POP) || (op == OP_MSW) || (op == OP_RET);
  endfunction

endpackage

// File: rtl/stack_unit_if.sv
// rtl/stack_unit_if.sv - request handshake and RAM-control bundle of the stack unit
interface stack_unit_if;
  import meh16_pkg::*;

  logic        op_valid;
  logic [2:0]  op;
  logic [9:0]  offset;
  logic        op_ready;
  logic [15:0] sp_out;
  logic        stack_load;
  logic        mar_stack;
  logic [11:0] stack_addr;
  logic        stk_ram_en;
  logic        done;
  logic        ovf;
  logic        udf;

  modport master (
    output op_valid, op, offset,
    input  op_ready, sp_out, stack_load, mar_stack, stack_addr, stk_ram_en, done, ovf, udf
  );

  modport slave (
    input  op_valid, op, offset,
    output op_ready, sp_out, stack_load, mar_stack, stack_addr, stk_ram_en, done, ovf, udf
  );

endinterface

// File: rtl/stack_unit_guard.sv
// rtl/stack_unit_guard.sv - combinational overflow/underflow detection, active only with STACK_GUARD_EN
module stack_guard
  import meh16_pkg::*;
#(
  parameter logic [11:0] STACK_TOP   = STACK_TOP_DEF,
  parameter logic [11:0] STACK_LIMIT = STACK_LIMIT_DEF
) (
  input  logic [11:0] sp,
  input  logic [2:0]  op,
  input  logic [9:0]  offset,
  output logic        ovf_hit,
  output logic        udf_hit
);

`ifdef STACK_GUARD_EN
  // 13-bit target so a wrap past 4095 shows up in bit 12.
  logic [12:0] target;

  // RET is checked against its final SP, which is never below its read address.
  always_comb begin
    target = {1'b0, sp} + 13'd1;
    if ((op == OP_MSW) || (op == OP_RET)) begin
      target = target + {3'b000, offset};
    end
    ovf_hit = is_write_op(op) && (sp < STACK_LIMIT);
    udf_hit = is_read_op(op) && (target[12] || (target[11:0] > STACK_TOP));
  end
`else
  logic unused_guard_inputs;
  assign unused_guard_inputs = &{1'b0, sp, op, offset, STACK_TOP, STACK_LIMIT};
  assign ovf_hit = 1'b0;
  assign udf_hit = 1'b0;
`endif

endmodule

// File: rtl/stack_unit.sv
// rtl/stack_unit.sv - downward-growing hardware stack sequencer; optional bounds checks under STACK_GUARD_EN
module stack_unit
  import meh16_pkg::*;
#(
  parameter logic [11:0] STACK_TOP   = STACK_TOP_DEF,
  parameter logic [11:0] STACK_LIMIT = STACK_LIMIT_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  stack_unit_if.slave  bus
);

  state_e      state_q, state_d;
  logic [11:0] sp_q;
  logic [11:0] sp_tgt_q, sp_tgt_d;
  logic [11:0] addr_q, addr_d;
  logic        rd_q, rd_d;
  logic        done_q, done_d;
  logic        ovf_q, udf_q;
  logic        accept;
  logic        ovf_hit, udf_hit;
  logic [11:0] off_ext;

  assign accept  = bus.op_valid && (state_q == ST_IDLE);
  assign off_ext = {2'b00, bus.offset};

  stack_guard #(
    .STACK_TOP   (STACK_TOP),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_guard (
    .sp      (sp_q),
    .op      (bus.op),
    .offset  (bus.offset),
    .ovf_hit (ovf_hit),
    .udf_hit (udf_hit)
  );

  // Next state; read address and the SP value applied in CMP are fixed at accept.
  always_comb begin
    state_d  = state_q;
    sp_tgt_d = sp_tgt_q;
    addr_d   = addr_q;
    rd_d     = rd_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sp_tgt_d = sp_q;
          rd_d     = 1'b0;
          if (ovf_hit || udf_hit) begin
            state_d = ST_CMP;
          end else begin
            case (bus.op)
              OP_PSH, OP_CAL: state_d = ST_WR;
              OP_POP: begin
                state_d  = ST_RD;
                rd_d     = 1'b1;
                addr_d   = sp_q + 12'd1;
                sp_tgt_d = sp_q + 12'd1;
              end
              OP_MSW: begin
                state_d = ST_RD;
                rd_d    = 1'b1;
                addr_d  = sp_q + 12'd1 + off_ext;
              end
              OP_RET: begin
                state_d  = ST_RD;
                rd_d     = 1'b1;
                addr_d   = sp_q + 12'd1;
                sp_tgt_d = sp_q + 12'd1 + off_ext;
              end
              default: state_d = ST_CMP;
            endcase
          end
        end
      end
      ST_WR:   state_d = ST_IDLE;
      ST_RD:   state_d = ST_CMP;
      default: state_d = ST_IDLE;
    endcase
    // done lands the cycle after WR, or during CMP.
    done_d = (state_q == ST_WR) || (state_d == ST_CMP);
  end

  // State, SP and sticky flags; reset wins over the pending SP decrement in WR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sp_q     <= STACK_TOP;
      sp_tgt_q <= STACK_TOP;
      addr_q   <= 12'h000;
      rd_q     <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sp_tgt_q <= sp_tgt_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      done_q   <= done_d;
      if (state_q == ST_WR) begin
        sp_q <= sp_q - 12'd1;
      end else if (state_q == ST_CMP) begin
        sp_q <= sp_tgt_q;
      end
      if (accept && ovf_hit) ovf_q <= 1'b1;
      if (accept && udf_hit) udf_q <= 1'b1;
    end
  end

  assign bus.op_ready   = (state_q == ST_IDLE);
  assign bus.sp_out     = {4'h0, sp_q};
  assign bus.stack_load = (state_q == ST_WR);
  assign bus.stk_ram_en = (state_q == ST_RD);
  assign bus.mar_stack  = rd_q && ((state_q == ST_RD) || (state_q == ST_CMP));
  assign bus.stack_addr = addr_q;
  assign bus.done       = done_q;
  assign bus.ovf        = ovf_q;
  assign bus.udf        = udf_q;

endmodule

// File: tb/tb_stack_unit.sv
// tb/tb_stack_unit.sv - directed self-checking bench for stack_unit
module tb_stack_unit;
  import meh16_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  stack_unit_if bus();

  stack_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request at a negedge; returns at the negedge one cycle after accept.
  task automatic do_op(input logic [2:0] o, input logic [9:0] off);
    bus.op_valid = 1'b1;
    bus.op       = o;
    bus.offset   = off;
    @(posedge clk);
    #1 bus.op_valid = 1'b0;
    @(negedge clk);
  endtask

  // Full operation; returns at a negedge with the unit idle and SP settled.
  task automatic run_op(input logic [2:0] o, input logic [9:0] off);
    do_op(o, off);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.op_valid = 1'b0;
    bus.op       = OP_NOP;
    bus.offset   = 10'd0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sp", bus.sp_out, 16'h0FFF);
    check("rst_done", {15'd0, bus.done}, 16'd0);
    check("rst_load", {15'd0, bus.stack_load}, 16'd0);
    check("rst_mar", {15'd0, bus.mar_stack}, 16'd0);
    check("rst_flags", {14'd0, bus.ovf, bus.udf}, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", {15'd0, bus.op_ready}, 16'd1);

    // PSH from empty stack
    do_op(OP_PSH, 10'd0);
    check("psh_load", {15'd0, bus.stack_load}, 16'd1);
    check("psh_wr_sp", bus.sp_out, 16'h0FFF);
    check("psh_busy", {15'd0, bus.op_ready}, 16'd0);
    check("psh_nodone", {15'd0, bus.done}, 16'd0);
    @(negedge clk);
    check("psh_done", {15'd0, bus.done}, 16'd1);
    check("psh_sp", bus.sp_out, 16'h0FFE);
    check("psh_load_off", {15'd0, bus.stack_load}, 16'd0);
    @(negedge clk);
    check("psh_pulse", {15'd0, bus.done}, 16'd0);

    // second PSH then POP
    run_op(OP_PSH, 10'd0);
    check("psh2_sp", bus.sp_out, 16'h0FFD);
    do_op(OP_POP, 10'd0);
    check("pop_addr", {4'h0, bus.stack_addr}, 16'h0FFE);
    check("pop_en", {15'd0, bus.stk_ram_en}, 16'd1);
    check("pop_mar", {15'd0, bus.mar_stack}, 16'd1);
    check("pop_nodone", {15'd0, bus.done}, 16'd0);
    @(negedge clk);
    check("pop_done", {15'd0, bus.done}, 16'd1);
    check("pop_mar_cmp", {15'd0, bus.mar_stack}, 16'd1);
    check("pop_addr_cmp", {4'h0, bus.stack_addr}, 16'h0FFE);
    check("pop_en_off", {15'd0, bus.stk_ram_en}, 16'd0);
    @(negedge clk);
    check("pop_sp", bus.sp_out, 16'h0FFE);

    // MSW at SP=FFC offset 2
    run_op(OP_PSH, 10'd0);
    run_op(OP_PSH, 10'd0);
    check("msw_pre_sp", bus.sp_out, 16'h0FFC);
    do_op(OP_MSW, 10'd2);
    check("msw_addr", {4'h0, bus.stack_addr}, 16'h0FFF);
    @(negedge clk);
    check("msw_done", {15'd0, bus.done}, 16'd1);
    @(negedge clk);
    check("msw_sp", bus.sp_out, 16'h0FFC);

    // RET at SP=FFB offset 3
    run_op(OP_PSH, 10'd0);
    do_op(OP_RET, 10'd3);
    check("ret_addr", {4'h0, bus.stack_addr}, 16'h0FFC);
    @(negedge clk);
    check("ret_done", {15'd0, bus.done}, 16'd1);
    @(negedge clk);
    check("ret_sp", bus.sp_out, 16'h0FFF);

    // NOP and an unused code both finish via CMP without strobes
    do_op(OP_NOP, 10'd0);
    check("nop_done", {15'd0, bus.done}, 16'd1);
    check("nop_strobes", {13'd0, bus.stack_load, bus.stk_ram_en, bus.mar_stack}, 16'd0);
    @(negedge clk);
    do_op(3'd7, 10'd5);
    check("op7_done", {15'd0, bus.done}, 16'd1);
    check("op7_strobes", {13'd0, bus.stack_load, bus.stk_ram_en, bus.mar_stack}, 16'd0);
    @(negedge clk);
    check("op7_sp", bus.sp_out, 16'h0FFF);

    // request held during WR is ignored
    bus.op_valid = 1'b1;
    bus.op       = OP_PSH;
    @(posedge clk);
    #1 bus.op = OP_POP;
    @(negedge clk);
    check("hold_wr", {15'd0, bus.stack_load}, 16'd1);
    @(posedge clk);
    #1 bus.op_valid = 1'b0;
    @(negedge clk);
    check("hold_sp", bus.sp_out, 16'h0FFE);
    @(negedge clk);
    check("hold_idle", {14'd0, bus.stk_ram_en, bus.mar_stack}, 16'd0);
    check("hold_sp2", bus.sp_out, 16'h0FFE);
    run_op(OP_POP, 10'd0);
    check("back_sp", bus.sp_out, 16'h0FFF);

    // reset during WR suppresses the decrement
    do_op(OP_PSH, 10'd0);
    check("rwr_load", {15'd0, bus.stack_load}, 16'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rwr_sp", bus.sp_out, 16'h0FFF);
    check("rwr_done", {15'd0, bus.done}, 16'd0);
    check("rwr_load_off", {15'd0, bus.stack_load}, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rwr_ready", {15'd0, bus.op_ready}, 16'd1);
    check("rwr_sp2", bus.sp_out, 16'h0FFF);

`ifdef STACK_GUARD_EN
    // underflow: POP on empty stack
    do_op(OP_POP, 10'd0);
    check("udf_flag", {15'd0, bus.udf}, 16'd1);
    check("udf_done", {15'd0, bus.done}, 16'd1);
    check("udf_strobes", {13'd0, bus.stack_load, bus.stk_ram_en, bus.mar_stack}, 16'd0);
    @(negedge clk);
    check("udf_sp", bus.sp_out, 16'h0FFF);
    // overflow: fill 1024 words, then one more PSH
    for (int i = 0; i < 1024; i++) run_op(OP_PSH, 10'd0);
    check("fill_sp", bus.sp_out, 16'h0BFF);
    check("fill_ovf", {15'd0, bus.ovf}, 16'd0);
    do_op(OP_PSH, 10'd0);
    check("ovf_flag", {15'd0, bus.ovf}, 16'd1);
    check("ovf_noload", {15'd0, bus.stack_load}, 16'd0);
    check("ovf_done", {15'd0, bus.done}, 16'd1);
    @(negedge clk);
    check("ovf_sp", bus.sp_out, 16'h0BFF);
`else
    // unguarded POP on empty stack wraps to 000
    do_op(OP_POP, 10'd0);
    check("wrap_addr", {4'h0, bus.stack_addr}, 16'h0000);
    check("wrap_en", {15'd0, bus.stk_ram_en}, 16'd1);
    repeat (2) @(negedge clk);
    check("wrap_sp", bus.sp_out, 16'h0000);
    check("wrap_flags", {14'd0, bus.ovf, bus.udf}, 16'd0);
    run_op(OP_PSH, 10'd0);
    check("wrap_back", bus.sp_out, 16'h0FFF);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 SHALL have parameter STACK_TOP, default 12'hFFF: address of the first (empty-stack) slot; the stack grows downward.
REQ-002 SHALL have parameter STACK_LIMIT, default 12'hC00: lowest writable stack address (1024-word region).
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  reset; synchronous, active-low.
REQ-005 op_valid  in  1  operation request.
REQ-006 op  in  3  NOP=0, PSH=1, POP=2, MSW=3, CAL=4, RET=5; codes 6-7 are treated as NOP.
REQ-007 offset  in  10  S field (distance above SP) for MSW and RET; ignored otherwise.
REQ-008 op_ready  out  1  high only in IDLE; a request is accepted when op_valid && op_ready.
REQ-009 sp_out  out  16  current SP; upper 4 bits always 0; drives the RAM stack-write address.
REQ-010 stack_load  out  1  RAM write strobe: bus is written to ram[sp_out].
REQ-011 mar_stack  out  1  selects stack_addr onto the RAM read address.
REQ-012 stack_addr  out  12  stack read address.
REQ-013 stk_ram_en  out  1  RAM read enable for stack reads.
REQ-014 done  out  1  one-cycle pulse when an operation completes; RAM out holds read data in this cycle for POP/MSW/RET.
REQ-015 ovf, udf  out  1 each  sticky overflow / underflow flags.

Function
REQ-016 States SHALL be IDLE, WR, RD, CMP; all strobe outputs SHALL be 0 except in the states listed below.
REQ-017 PSH/CAL accept SHALL go IDLE->WR; in WR: stack_load=1, sp_out=SP; on WR exit SP<=SP-1, done=1, ->IDLE (done occurs 2 cycles after accept).
REQ-018 POP accept SHALL go IDLE->RD with stack_addr=SP+1, mar_stack=1, stk_ram_en=1; then RD->CMP: done=1, SP<=SP+1, ->IDLE.
REQ-019 MSW SHALL behave like POP with stack_addr=SP+1+offset and SP unchanged.
REQ-020 RET SHALL read at SP+1 (return address) and in CMP set SP<=SP+1+offset.
REQ-021 NOP SHALL go IDLE->CMP with done=1 and no RAM strobes.
REQ-022 Address arithmetic SHALL be 12-bit modulo 4096; offset is zero-extended.
REQ-023 op_valid outside IDLE SHALL be ignored; a request is never queued.
REQ-024 stack_addr and mar_stack SHALL remain stable through RD and CMP.

Reset
REQ-025 On rst_n=0 at a clock edge: state=IDLE, SP=STACK_TOP, ovf=udf=0, done=stack_load=mar_stack=stk_ram_en=0; reset in WR SHALL suppress the pending SP update (the write in progress this cycle is the only one permitted).
REQ-026 After reset, op_ready SHALL be 1 on the first cycle following the edge with rst_n=1.

Configuration
REQ-027 Macro STACK_GUARD_EN: when defined, PSH/CAL with SP<STACK_LIMIT, or POP/RET/MSW with a target address > STACK_TOP or a 12-bit sum wrap, SHALL set ovf/udf respectively, suppress all RAM strobes, leave SP unchanged, and still pulse done via CMP.
REQ-028 When STACK_GUARD_EN is not defined, no checks SHALL occur, ovf=udf=0 constant, and SP wraps per REQ-022.

Structure
REQ-029 The op encodings and the STACK_TOP/STACK_LIMIT defaults SHALL live in shared package meh16_pkg.
REQ-030 Guard comparisons SHALL be in sub-module stack_guard (combinational; SP, op, offset in; ovf_hit, udf_hit out); all other logic is flat.

Verification
REQ-031 Reset, then PSH -> stack_load=1 with sp_out=0x0FFF; done 2 cycles after accept; sp_out=0x0FFE.
REQ-032 PSH x2, then POP -> stack_addr=0x0FFE, stk_ram_en=1; done next cycle; SP=0x0FFE.
REQ-033 SP=0x0FFC, MSW offset=2 -> stack_addr=0x0FFF; SP stays 0x0FFC.
REQ-034 SP=0x0FFB, RET offset=3 -> read at 0x0FFC; SP becomes 0x0FFF.
REQ-035 GUARD_EN: POP at SP=0x0FFF -> udf=1, no strobes, done pulses, SP=0x0FFF; fill to SP=0x0BFF, PSH -> ovf=1, no write.
REQ-036 Reset asserted during WR of a PSH at SP=0x0FFF -> SP=0x0FFF, state IDLE, op_ready=1 after release.
